// File: rtl/uart_fifo_tx_pkg.sv
// Shared UART/FIFO constants and types for the CSR-fed UART transmit path.
// Defaults describe the board build; instances may override depth and bit period.
package uart_fifo_tx_pkg;

    localparam int FifoQueueSize = 256;
    localparam int FifoPtrSize   = $clog2(FifoQueueSize);
    localparam int UartCmpVal    = 173;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] RegT;

    typedef logic [FifoPtrSize-1:0]          FifoPtrT;
    typedef logic [FifoPtrSize:0]            FifoCountT;
    typedef logic [$clog2(UartCmpVal+1)-1:0] UartBaudCntT;

    localparam CsrAddrT FifoWordCsrAddr = 12'h050;
    localparam CsrAddrT FifoByteCsrAddr = 12'h051;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UartStateT;

    // Status word returned on a FIFO CSR read: sticky overflow in bit 31, fill level below.
    function automatic RegT fifo_status(input logic ovf, input logic [8:0] cnt);
        return {ovf, 22'b0, cnt};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts one byte per valid/ready handshake while idle, CmpVal cycles per bit.
// tx is registered (one cycle behind the FSM); ready only in IDLE, so back-to-back frames get one idle cycle.
module uart_tx_serializer
    import uart_fifo_tx_pkg::*;
#(
    parameter int CmpVal = UartCmpVal
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_dat_i,
    output logic       byte_rdy_o,
    output logic       tx_o
);

    localparam int BaudW = $clog2(CmpVal + 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CmpVal - 1);

    UartStateT        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_end;

    assign baud_end   = (baud_q == BaudLast);
    assign byte_rdy_o = (state_q == IDLE);
    assign tx_o       = tx_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (byte_vld_i) begin
                    shift_d = byte_dat_i;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// CSR-fed UART transmitter: byte/word CSR writes fill a byte FIFO drained by an 8N1 serializer.
// Start bit appears 2 cycles after the write edge; a full FIFO drops the write and sets sticky overflow.
module uart_fifo_tx
    import uart_fifo_tx_pkg::*;
#(
    parameter int      QueueSize = FifoQueueSize,
    parameter int      CmpVal    = UartCmpVal,
    parameter CsrAddrT WordAddr  = FifoWordCsrAddr,
    parameter CsrAddrT ByteAddr  = FifoByteCsrAddr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_enable,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_data,
    output logic [31:0] csr_out,
    output logic        tx,
    output logic        busy
);

    localparam int PtrW = $clog2(QueueSize);
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    localparam cnt_t Full      = cnt_t'(QueueSize);
    localparam cnt_t WordLimit = cnt_t'(QueueSize - 4);

    logic [7:0] mem_q [QueueSize];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    logic       ovf_q, ovf_d;

    logic addr_word, addr_byte, word_hit, byte_hit;
    logic word_ok, byte_ok, drop, ovf_clr;
    logic ser_rdy, pop;
    cnt_t push_n;

    assign addr_word = (csr_addr == WordAddr);
    assign addr_byte = (csr_addr == ByteAddr);
    assign word_hit  = csr_enable && csr_we && addr_word;
    assign byte_hit  = csr_enable && csr_we && addr_byte;

    // Space is judged on the registered count only, so a same-cycle pop never makes room.
    assign byte_ok = byte_hit && (count_q < Full);
    assign word_ok = word_hit && (count_q <= WordLimit);
    assign drop    = (byte_hit && !byte_ok) || (word_hit && !word_ok);
    assign ovf_clr = (word_hit || byte_hit) && csr_data[31];

    assign pop = ser_rdy && (count_q != '0);

    always_comb begin
        push_n = '0;
        if (byte_ok) begin
            push_n = cnt_t'(1);
        end else if (word_ok) begin
            push_n = cnt_t'(4);
        end

        wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        count_d  = count_q + push_n - cnt_t'(pop);

        // A dropped push re-raises overflow even when the same write asks for a clear.
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; a word may straddle the wrap point.
    always_ff @(posedge clk) begin
        if (byte_ok) begin
            mem_q[wr_ptr_q] <= csr_data[7:0];
        end
        if (word_ok) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[wr_ptr_q + ptr_t'(k)] <= csr_data[8*k +: 8];
            end
        end
    end

    uart_tx_serializer #(
        .CmpVal(CmpVal)
    ) u_ser (
        .clk_i      (clk),
        .reset_i    (reset),
        .byte_vld_i (count_q != '0),
        .byte_dat_i (mem_q[rd_ptr_q]),
        .byte_rdy_o (ser_rdy),
        .tx_o       (tx)
    );

    assign csr_out = (addr_word || addr_byte) ? fifo_status(ovf_q, 9'(count_q)) : '0;
    assign busy    = (count_q != '0) || !ser_rdy;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Randomized bench: queue-based FIFO model with frame-timing rules, plus a UART receiver scoreboard.
module tb_uart_fifo_tx;

    localparam int          CMP   = 4;
    localparam int          QSZ   = 256;
    localparam int          FRAME = 10 * CMP + 1;
    localparam logic [11:0] WADDR = 12'h050;
    localparam logic [11:0] BADDR = 12'h051;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_enable = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = BADDR;
    logic [31:0] csr_data = '0;
    logic [31:0] csr_out;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    uart_fifo_tx #(
        .QueueSize (QSZ),
        .CmpVal    (CMP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_enable (csr_enable),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_data   (csr_data),
        .csr_out    (csr_out),
        .tx         (tx),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a byte queue, serializer as "free again at cycle X".
    int         cyc = 0;
    int         m_count = 0;
    bit         m_ovf = 1'b0;
    int         m_wr = 0;
    int         m_free_at = 0;
    int         last_push_cyc = 0;
    logic [7:0] q_exp[$];
    int         rx_starts[$];

    always @(posedge clk) begin : model
        bit pop;
        bit hitw;
        bit hitb;
        int add;
        cyc++;
        if (reset) begin
            m_count   = 0;
            m_ovf     = 1'b0;
            m_wr      = 0;
            m_free_at = cyc + 1;
            q_exp.delete();
        end else begin
            pop  = (cyc >= m_free_at) && (m_count > 0);
            hitw = csr_enable && csr_we && (csr_addr == WADDR);
            hitb = csr_enable && csr_we && (csr_addr == BADDR);
            add  = 0;
            if ((hitw || hitb) && csr_data[31]) m_ovf = 1'b0;
            if (hitb) begin
                if (m_count < QSZ) begin
                    q_exp.push_back(csr_data[7:0]);
                    add = 1;
                    last_push_cyc = cyc;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (hitw) begin
                if (m_count <= QSZ - 4) begin
                    for (int k = 0; k < 4; k++) q_exp.push_back(csr_data[8*k +: 8]);
                    add = 4;
                    last_push_cyc = cyc;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_wr = (m_wr + add) % QSZ;
            if (pop) m_free_at = cyc + FRAME;
            m_count = m_count + add - (pop ? 1 : 0);
        end
    end

    function automatic bit m_busy();
        return (m_count != 0) || (cyc + 1 < m_free_at);
    endfunction

    // UART receiver: decodes frames from tx and compares against the expected byte stream.
    int         rx_ph = -1;
    logic [7:0] rx_sh = '0;
    logic       rx_cur = 1'b1;
    bit         rx_bad = 1'b0;

    always @(negedge clk) begin : monitor
        int b;
        logic [7:0] exp_b;
        if (reset) begin
            rx_ph = -1;
        end else if (rx_ph < 0) begin
            if (tx === 1'b0) begin
                rx_ph  = 1;
                rx_cur = 1'b0;
                rx_bad = 1'b0;
                rx_sh  = '0;
                rx_starts.push_back(cyc);
            end
        end else begin
            b = rx_ph / CMP;
            if (rx_ph % CMP == 0) begin
                rx_cur = tx;
                if (b >= 1 && b <= 8) rx_sh[b-1] = tx;
                if (b == 9 && tx !== 1'b1) rx_bad = 1'b1;
            end else if (tx !== rx_cur) begin
                rx_bad = 1'b1;
            end
            if (rx_ph == 10 * CMP - 1) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL frame: received %02h but no byte was expected", rx_sh);
                end else begin
                    exp_b = q_exp.pop_front();
                    if (rx_bad || rx_sh !== exp_b) begin
                        errors++;
                        $display("FAIL frame: received %02h (bad_framing=%0d), expected %02h",
                                 rx_sh, rx_bad, exp_b);
                    end
                end
                rx_ph = -1;
            end else begin
                rx_ph++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    task automatic check_csr(input string name);
        check(name, csr_out, {m_ovf, 22'b0, 9'(m_count)});
    endtask

    task automatic set_bus(input bit en, input bit we, input logic [11:0] a, input logic [31:0] d);
        csr_enable = en;
        csr_we     = we;
        csr_addr   = a;
        csr_data   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q_exp.size() != 0 || rx_ph >= 0 || m_count != 0 || m_busy()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, %0d bytes outstanding",
                     name, budget, q_exp.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int pushed;
        int n;
        bit want_word;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check_csr("reset_csr");

        // Test 1: reads and foreign writes have no effect; single byte 0x55.
        tick(); set_bus(1, 0, BADDR, 32'hFFFF_FF12);
        tick(); set_bus(1, 1, 12'h052, 32'h0000_0034);
        tick(); set_bus(0, 0, 12'h123, '0);
        @(negedge clk);
        check("t1_nomatch_csr", csr_out, 32'd0);
        check_csr("t1_no_side_effect");
        rx_starts.delete();
        tick(); set_bus(1, 1, BADDR, 32'h0000_0055);
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check_csr("t1_count_one");
        check("t1_busy_after_push", 32'(busy), 32'(m_busy()));
        check("t1_tx_still_idle", 32'(tx), 32'd1);
        @(negedge clk);
        check_csr("t1_count_zero");
        wait_idle("t1_drain", 200);
        check("t1_frames", rx_starts.size(), 32'd1);
        if (rx_starts.size() > 0) check("t1_start_latency", rx_starts[0] - last_push_cyc, 32'd2);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_tx_done", 32'(tx), 32'd1);

        // Test 2: word push, byte order and start-to-start spacing.
        rx_starts.delete();
        tick(); set_bus(1, 1, WADDR, 32'hDEAD_BEEF);
        tick(); set_bus(0, 0, BADDR, '0);
        wait_idle("t2_drain", 400);
        check("t2_frames", rx_starts.size(), 32'd4);
        for (int i = 1; i < rx_starts.size(); i++)
            check("t2_gap", rx_starts[i] - rx_starts[i-1], FRAME);

        // Test 3: fill to 253, word dropped, byte accepted, bit31 write clears overflow.
        guard = 0;
        while (guard < 3000) begin
            tick();
            set_bus(0, 0, BADDR, '0);
            if (m_count == 253) break;
            if (m_count <= QSZ - 7) set_bus(1, 1, WADDR, $urandom & 32'h7FFF_FFFF);
            else set_bus(1, 1, BADDR, $urandom_range(0, 255));
            guard++;
        end
        check("t3_reached_253", m_count, 32'd253);
        set_bus(1, 1, WADDR, 32'h0102_0304);
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check("t3_ovf_set", 32'(csr_out[31]), 32'd1);
        check_csr("t3_word_dropped");
        tick(); set_bus(1, 1, BADDR, 32'h0000_005A);
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check_csr("t3_byte_after_drop");
        tick(); set_bus(1, 1, BADDR, 32'h8000_00C3);
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check("t3_ovf_cleared", 32'(csr_out[31]), 32'd0);
        check_csr("t3_clear_pushes");

        // Test 4: full FIFO, push lands on the same edge as a pop -> dropped.
        guard = 0;
        while (guard < 3000) begin
            tick();
            set_bus(0, 0, BADDR, '0);
            if (m_count == QSZ && cyc + 1 >= m_free_at) begin
                set_bus(1, 1, BADDR, 32'h0000_0077);
                break;
            end else if (m_count < QSZ) begin
                set_bus(1, 1, BADDR, $urandom_range(0, 255));
            end
            guard++;
        end
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check("t4_count_255", 32'(csr_out[8:0]), 32'd255);
        check("t4_ovf", 32'(csr_out[31]), 32'd1);
        check_csr("t4_csr");
        tick(); set_bus(1, 1, BADDR, 32'h8000_0042);
        tick(); set_bus(0, 0, BADDR, '0);
        @(negedge clk);
        check_csr("t4_clear");
        wait_idle("t4_drain", 12000);

        // Test 5: 300 random bytes with concurrent drain; a word straddles index 255/0.
        pushed = 0;
        guard = 0;
        while (pushed < 300 && guard < 20000) begin
            tick();
            set_bus(0, 0, BADDR, '0);
            if (m_wr >= 253) want_word = 1'b1;
            else if (m_wr >= 250) want_word = 1'b0;
            else want_word = ($urandom_range(0, 1) == 1);
            if (pushed + 4 > 300) want_word = 1'b0;
            if (want_word && m_count <= QSZ - 4) begin
                set_bus(1, 1, WADDR, $urandom & 32'h7FFF_FFFF);
                pushed += 4;
            end else if (!want_word && m_count < QSZ) begin
                set_bus(1, 1, BADDR, $urandom_range(0, 255));
                pushed += 1;
            end
            guard++;
        end
        tick(); set_bus(0, 0, BADDR, '0);
        check("t5_pushed", pushed, 32'd300);
        wait_idle("t5_drain", 15000);

        // Test 6: reset during DATA bit 3 aborts everything; next frame is clean.
        rx_starts.delete();
        tick(); set_bus(1, 1, WADDR, 32'h1122_3344);
        tick(); set_bus(0, 0, BADDR, '0);
        n = 0;
        while (rx_starts.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_start_seen", 32'(rx_starts.size() != 0), 32'd1);
        repeat (16) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_tx_high", 32'(tx), 32'd1);
        check("t6_busy_low", 32'(busy), 32'd0);
        check_csr("t6_count_zero");
        tick(); set_bus(1, 1, BADDR, 32'h0000_00A5);
        tick(); set_bus(0, 0, BADDR, '0);
        wait_idle("t6_drain", 200);
        check("t6_all_received", q_exp.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- CSR-mapped UART transmit path: software writes bytes or words to the FIFO CSRs (0x50 word, 0x51 byte).
- Bytes are buffered in a FifoQueueSize-deep byte FIFO and serialized 8N1 on `tx` at CoreFreq/UartBaudRate.
- Sits downstream of the CSR decode stage and consumes the UART/FIFO constants from config_pkg.
- Drives the board TX pin.

Parameters:
- QueueSize, FifoQueueSize (256): FIFO depth in bytes; power of two, ≥ 4.
- CmpVal, UartCmpVal (173): clock cycles per UART bit. Benches override it with a small value.
- WordAddr, FifoWordCsrAddr (0x50): CSR address for a word push.
- ByteAddr, FifoByteCsrAddr (0x51): CSR address for a byte push.

Ports:
- clk  in  1  core clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- csr_enable  in  1  CSR access strobe this cycle.
- csr_we  in  1  CSR access is a write (csrrw/csrrs with nonzero source).
- csr_addr  in  12  CSR address (CsrAddrT).
- csr_data  in  32  write data (RegT).
- csr_out  out  32  read data: {overflow, 22'b0, count[8:0]} on address match, else 0. Combinational.
- tx  out  1  serial output; idle high.
- busy  out  1  high when the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (synchronous, active-high):
  - rd_ptr = wr_ptr = 0, count = 0, overflow = 0.
  - Serializer returns to IDLE and its baud counter = 0.
  - tx = 1 and busy = 0 from the first cycle after reset is sampled.
  - Reset mid-frame aborts the frame: tx goes high the next cycle and any partial frame is lost.
- Byte push: csr_enable & csr_we & addr==ByteAddr.
  - If count < QueueSize: mem[wr_ptr] = csr_data[7:0]; wr_ptr += 1.
  - Otherwise the byte is dropped and overflow is set (sticky).
- Word push: same strobe with addr==WordAddr.
  - If count ≤ QueueSize-4: write bytes [7:0], [15:8], [23:16], [31:24] to wr_ptr..wr_ptr+3 in the same cycle; wr_ptr += 4.
  - Otherwise the whole word is dropped (never a partial word) and overflow is set.
- Pointers are log2(QueueSize) bits and wrap modulo QueueSize. A word may straddle the wrap.
- count is log2(QueueSize)+1 bits. Each cycle: count_next = count + pushed − popped; simultaneous push and pop are both honoured.
- Full/empty tests use the registered count at the start of the cycle. A pop in the same cycle does not free space for that cycle's push.
- CSR reads have no side effects.
  - Any write to either FIFO address with csr_data[31] = 1 and csr_we clears overflow. This is a debug escape: the payload is still pushed.
- Serializer FSM:
  - IDLE: tx = 1. When count != 0, pop mem[rd_ptr] into the shift register (rd_ptr += 1, count −= 1), baud counter = 0, go to START.
  - START: tx = 0 for CmpVal cycles, then go to DATA with bit index = 0.
  - DATA: tx = shift[0], LSB first; shift right every CmpVal cycles. After bit 7, go to STOP.
  - STOP: tx = 1 for CmpVal cycles, then IDLE. Next-start check happens in that same IDLE cycle, so back-to-back frames are separated by exactly 1 IDLE cycle.
- Frame length: 10·CmpVal + 1 cycles per byte when streaming.
- Latency: a push into an empty, idle FIFO shows on the cycle after the write. Next cycle IDLE sees count = 1; start bit on tx one cycle later (2 cycles after the write edge).
- Baud counter counts 0..CmpVal−1; its width is $clog2(CmpVal+1).
- busy = (count != 0) | (state != IDLE).

Decomposition:
- config_pkg gains:
  - UartStateT enum {IDLE, START, DATA, STOP}
  - UartBaudCntT = logic[$clog2(UartCmpVal+1)-1:0]
  - FifoCountT = logic[FifoPtrSize:0]
- Existing FifoPtrT, FifoWordCsrAddr, FifoByteCsrAddr and UartCmpVal are reused.
- Sub-module uart_tx_serializer: byte-in valid/ready handshake, FSM, baud counter, tx output.
- The top holds the FIFO storage, pointers, count, overflow and CSR decode. It pops when serializer ready & count != 0.

Test Plan (CmpVal = 4 unless stated):
1. Reset, then byte push 0x55 → tx low for 4 cycles starting 2 cycles after the write, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles; busy drops after the stop; csr_out count reads 1→0.
2. Word push 0xDEADBEEF → bytes EF, BE, AD, DE transmitted in order; inter-frame gap is exactly 1 idle cycle (41 cycles start-to-start).
3. Fill to 253 bytes, then word push → dropped, count stays 253, overflow = 1. Next byte push still succeeds (count 254). Write with bit31 = 1 clears overflow.
4. Fill to 256 while the serializer pops in the same cycle as a byte push → push dropped (registered-full rule), count = 255 next cycle, overflow = 1.
5. Wrap: push 300 bytes total with concurrent drain, including a word straddling index 255/0 → received byte stream matches pushed order exactly.
6. Assert reset during DATA bit 3 → tx = 1, busy = 0, count = 0 next cycle. A subsequent byte push 0xA5 transmits a clean frame.
